// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic SRC_EX  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback request channels, the hold control and the register-file write port.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) ();

  logic             hold;
  logic             ex_valid;
  logic             ex_ready;
  logic [AddrW-1:0] ex_addr;
  logic [DataW-1:0] ex_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_data;
  logic             rd_we;
  logic [AddrW-1:0] rd_addr;
  logic [DataW-1:0] rd_wdata;
  logic             wb_src;
  logic             busy;

  modport master (
    output hold, ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
    input  ex_ready, mem_ready, rd_we, rd_addr, rd_wdata, wb_src, busy
  );

  modport slave (
    input  hold, ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
    output ex_ready, mem_ready, rd_we, rd_addr, rd_wdata, wb_src, busy
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; a granted slot may be refilled in the same cycle.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] data_i,
  input  logic             grant_i,
  output logic             full_o,
  output logic [AddrW-1:0] addr_o,
  output logic [DataW-1:0] data_o
);

  logic             full_q, full_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             load;

  // Ready is forced low combinationally while reset is asserted.
  assign ready_o = rst_ni & (~full_q | grant_i);
  assign load    = valid_i & ready_o;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (grant_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the EX and MEM writeback slots.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input logic                clk_i,
  input logic                rst_ni,
  regfile_wb_arbiter_if.slave bus
);

  logic             ex_full, mem_full;
  logic [AddrW-1:0] ex_addr, mem_addr;
  logic [DataW-1:0] ex_data, mem_data;
  logic             grant_ex, grant_mem, any_grant;
  logic             sel_src;
  logic [AddrW-1:0] sel_addr;
  logic [DataW-1:0] sel_data;

  logic             rr_q, rr_d;
  logic             rd_we_q, rd_we_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic [DataW-1:0] rd_wdata_q, rd_wdata_d;
  logic             wb_src_q, wb_src_d;

  wb_slot #(.DataW(DataW), .AddrW(AddrW)) u_ex_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (bus.ex_valid),
    .ready_o (bus.ex_ready),
    .addr_i  (bus.ex_addr),
    .data_i  (bus.ex_data),
    .grant_i (grant_ex),
    .full_o  (ex_full),
    .addr_o  (ex_addr),
    .data_o  (ex_data)
  );

  wb_slot #(.DataW(DataW), .AddrW(AddrW)) u_mem_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (bus.mem_valid),
    .ready_o (bus.mem_ready),
    .addr_i  (bus.mem_addr),
    .data_i  (bus.mem_data),
    .grant_i (grant_mem),
    .full_o  (mem_full),
    .addr_o  (mem_addr),
    .data_o  (mem_data)
  );

  // The pointer only breaks ties; a lone full slot is always granted.
  always_comb begin
    grant_ex  = 1'b0;
    grant_mem = 1'b0;
    if (!bus.hold) begin
      if (ex_full && mem_full) begin
        grant_ex  = (rr_q == SRC_EX);
        grant_mem = (rr_q == SRC_MEM);
      end else begin
        grant_ex  = ex_full;
        grant_mem = mem_full;
      end
    end
  end

  assign any_grant = grant_ex | grant_mem;
  assign sel_src   = grant_mem ? SRC_MEM : SRC_EX;
  assign sel_addr  = grant_mem ? mem_addr : ex_addr;
  assign sel_data  = grant_mem ? mem_data : ex_data;

  always_comb begin
    rr_d       = rr_q;
    rd_we_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    wb_src_d   = wb_src_q;
    if (any_grant) begin
      rr_d       = ~sel_src;
      rd_we_d    = (sel_addr != AddrW'(ZERO_REG));
      rd_addr_d  = sel_addr;
      rd_wdata_d = sel_data;
      wb_src_d   = sel_src;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= SRC_EX;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      wb_src_q   <= SRC_EX;
    end else begin
      rr_q       <= rr_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign bus.rd_we    = rd_we_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_wdata = rd_wdata_q;
  assign bus.wb_src   = wb_src_q;
  assign bus.busy     = ex_full | mem_full | rd_we_q;

endmodule
